redmule_tile_sequencer: RTL and testbench

Sequencer directly downstream of the RedMulE controller. It consumes the controller's scheduler strobes (first_load, rst/finished) and the tiled iteration counts from the latched register file. It walks the M/N/K tile loop, issues W/X load requests and Z store requests to the streamer side, and returns w_loaded to the controller. It also reports per-tile indices and the accumulate/last flags to the datapath.

---
 rtl/redmule_pkg.sv | 29 ++
 rtl/redmule_tile_counter.sv | 42 ++++
 rtl/redmule_tile_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_redmule_tile_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// ----------------------------------------------------------------------------
// redmule_pkg
// Shared types and constants for the RedMulE tile sequencer.
//   - redmule_seq_state_e : tile sequencer FSM states
//   - redmule_tile_depth(): W tile depth in rows, (NumPipeRegs+1)*Height
//   - RedmuleTile         : W tile depth for the default array geometry
// ----------------------------------------------------------------------------
package redmule_pkg;

   localparam int unsigned RedmuleHeight      = 4;
   localparam int unsigned RedmuleWidth       = 8;
   localparam int unsigned RedmuleNumPipeRegs = 3;

   function automatic int unsigned redmule_tile_depth(input int unsigned height,
                                                      input int unsigned pipe_regs);
      return (pipe_regs + 1) * height;
   endfunction

   localparam int unsigned RedmuleTile = redmule_tile_depth(RedmuleHeight, RedmuleNumPipeRegs);

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_LOAD_W  = 3'd1,
      SEQ_LOAD_X  = 3'd2,
      SEQ_STORE_Z = 3'd3,
      SEQ_DONE    = 3'd4
   } redmule_seq_state_e;

endpackage

// File: rtl/redmule_tile_counter.sv
// ----------------------------------------------------------------------------
// redmule_tile_counter
// Wrapping tile index counter: counts 0 .. limit_i-1, then wraps to 0.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         synchronous clear to 0 (wins over en_i)
//   en_i            advance by one (wraps when at last)
//   limit_i         number of tiles (live, must be stable while counting)
//   cnt_o           current index
//   last_o          cnt_o == limit_i-1
// ----------------------------------------------------------------------------
module redmule_tile_counter #(
   parameter int unsigned CntWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                en_i,
   input  logic [CntWidth-1:0] limit_i,
   output logic [CntWidth-1:0] cnt_o,
   output logic                last_o
);

   logic [CntWidth-1:0] r_cnt;
   logic                w_last;

   assign w_last = (r_cnt == (limit_i - CntWidth'(1)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (clear_i) begin
         r_cnt <= '0;
      end else if (en_i) begin
         r_cnt <= w_last ? '0 : r_cnt + CntWidth'(1);
      end
   end

   assign cnt_o  = r_cnt;
   assign last_o = w_last;

endmodule

// File: rtl/redmule_tile_sequencer.sv
// ----------------------------------------------------------------------------
// redmule_tile_sequencer
// Walks the M/N/K tile loop (k innermost, then n, then m), issuing W/X load
// and Z store requests to the streamer and signalling W tile completion back
// to the RedMulE controller.
//
// Build option: REDMULE_SEQ_PERF_EN adds a saturating 32-bit handshake stall
// counter on stall_cnt_o; without it stall_cnt_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   clear_i                       synchronous clear (highest priority)
//   start_i                       start level, sampled in IDLE only
//   flush_i                       abort back to IDLE, no done pulse
//   m/n/k_tiles_i                 tile counts (stable while busy_o)
//   w_req_valid_o / w_req_ready_i W tile load request handshake
//   w_beat_valid_i                one W row delivered to the array
//   x_req_valid_o / x_req_ready_i X tile load request handshake
//   z_req_valid_o / z_req_ready_i Z tile store request handshake
//   w_loaded_o                    one-cycle pulse, W tile complete
//   m/n/k_idx_o                   current tile indices
//   accumulate_o                  k_idx_o != 0
//   last_o                        current tile is last in M, N and K
//   busy_o, done_o                activity level / end-of-sequence pulse
//   stall_cnt_o                   valid-without-ready cycle count
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start_i
// LOAD_W| W request (once per tile) and TILE beat collection
// LOAD_X| X request for the current k step
// STORE_Z| Z store after the last k step of an (m,n) tile
// DONE  | one-cycle end of sequence, indices cleared
// ----------------------------------------------------------------------------
module redmule_tile_sequencer
   import redmule_pkg::*;
#(
   parameter int unsigned Height      = RedmuleHeight,
   parameter int unsigned Width       = RedmuleWidth,
   parameter int unsigned NumPipeRegs = RedmuleNumPipeRegs,
   parameter int unsigned CntWidth    = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                start_i,
   input  logic                flush_i,
   input  logic [CntWidth-1:0] m_tiles_i,
   input  logic [CntWidth-1:0] n_tiles_i,
   input  logic [CntWidth-1:0] k_tiles_i,
   output logic                w_req_valid_o,
   input  logic                w_req_ready_i,
   input  logic                w_beat_valid_i,
   output logic                x_req_valid_o,
   input  logic                x_req_ready_i,
   output logic                z_req_valid_o,
   input  logic                z_req_ready_i,
   output logic                w_loaded_o,
   output logic [CntWidth-1:0] m_idx_o,
   output logic [CntWidth-1:0] n_idx_o,
   output logic [CntWidth-1:0] k_idx_o,
   output logic                accumulate_o,
   output logic                last_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [31:0]         stall_cnt_o
);

   localparam int unsigned TILE  = redmule_tile_depth(Height, NumPipeRegs);
   localparam int unsigned BeatW = $clog2(TILE + 1);

   if (Width == 0 || Height == 0) begin : g_cfg_check
      $error("redmule_tile_sequencer: array dimensions must be non-zero");
   end

   redmule_seq_state_e r_state, w_state_next;

   logic [BeatW-1:0] r_beat_cnt;
   logic             r_w_req_acc;   // W request of the current tile already accepted
   logic             r_w_loaded;
   logic             r_done;
   logic             r_busy;

   logic w_w_valid, w_x_valid, w_z_valid;
   logic w_w_hs, w_x_hs, w_z_hs;
   logic w_abort, w_counts_ok, w_beat_take, w_tile_loaded;
   logic w_m_last, w_n_last, w_k_last, w_all_last, w_idx_clear, w_active;
   logic w_k_en, w_n_en, w_m_en;

   assign w_w_valid = (r_state == SEQ_LOAD_W) && !r_w_req_acc;
   assign w_x_valid = (r_state == SEQ_LOAD_X);
   assign w_z_valid = (r_state == SEQ_STORE_Z);

   assign w_w_hs = w_w_valid && w_req_ready_i;
   assign w_x_hs = w_x_valid && x_req_ready_i;
   assign w_z_hs = w_z_valid && z_req_ready_i;

   assign w_abort     = clear_i || flush_i;
   assign w_counts_ok = (|m_tiles_i) && (|n_tiles_i) && (|k_tiles_i);

   // Beats only count once the tile's W request is (being) accepted, so
   // stray beats outside that window never leak into a tile.
   assign w_beat_take   = (r_state == SEQ_LOAD_W) && w_beat_valid_i && (r_w_req_acc || w_w_hs);
   assign w_tile_loaded = w_beat_take && (r_beat_cnt == BeatW'(TILE - 1));

   assign w_all_last  = w_m_last && w_n_last && w_k_last;
   assign w_idx_clear = w_abort || (r_state == SEQ_DONE);
   // At the Z handshake k is always last, so enabling it there wraps it to 0.
   assign w_k_en      = (w_x_hs && !w_k_last) || w_z_hs;
   assign w_n_en      = w_z_hs;
   assign w_m_en      = w_z_hs && w_n_last;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         SEQ_IDLE:    if (start_i) w_state_next = w_counts_ok ? SEQ_LOAD_W : SEQ_DONE;
         SEQ_LOAD_W:  if (w_tile_loaded) w_state_next = SEQ_LOAD_X;
         SEQ_LOAD_X:  if (w_x_hs) w_state_next = w_k_last ? SEQ_STORE_Z : SEQ_LOAD_W;
         SEQ_STORE_Z: if (w_z_hs) w_state_next = w_all_last ? SEQ_DONE : SEQ_LOAD_W;
         SEQ_DONE:    w_state_next = SEQ_IDLE;
         default:     w_state_next = SEQ_IDLE;
      endcase
      if (w_abort) w_state_next = SEQ_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= SEQ_IDLE;
         r_beat_cnt  <= '0;
         r_w_req_acc <= 1'b0;
         r_w_loaded  <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_busy     <= (w_state_next != SEQ_IDLE);
         r_done     <= (w_state_next == SEQ_DONE);
         r_w_loaded <= w_tile_loaded && !w_abort;
         if (w_abort || w_tile_loaded) begin
            r_beat_cnt  <= '0;
            r_w_req_acc <= 1'b0;
         end else begin
            if (w_beat_take) r_beat_cnt <= r_beat_cnt + BeatW'(1);
            if (w_w_hs)      r_w_req_acc <= 1'b1;
         end
      end
   end

   redmule_tile_counter #(.CntWidth(CntWidth)) i_k_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (w_idx_clear),
      .en_i    (w_k_en),
      .limit_i (k_tiles_i),
      .cnt_o   (k_idx_o),
      .last_o  (w_k_last)
   );

   redmule_tile_counter #(.CntWidth(CntWidth)) i_n_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (w_idx_clear),
      .en_i    (w_n_en),
      .limit_i (n_tiles_i),
      .cnt_o   (n_idx_o),
      .last_o  (w_n_last)
   );

   redmule_tile_counter #(.CntWidth(CntWidth)) i_m_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (w_idx_clear),
      .en_i    (w_m_en),
      .limit_i (m_tiles_i),
      .cnt_o   (m_idx_o),
      .last_o  (w_m_last)
   );

`ifdef REDMULE_SEQ_PERF_EN
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = (w_w_valid && !w_req_ready_i) ||
                    (w_x_valid && !x_req_ready_i) ||
                    (w_z_valid && !z_req_ready_i);

   // Flush keeps the count so an aborted run can still be inspected.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
      end else if (clear_i) begin
         r_stall_cnt <= '0;
      end else if (flush_i) begin
         r_stall_cnt <= r_stall_cnt;
      end else if ((r_state == SEQ_IDLE) && start_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = 32'd0;
`endif

   // Index-derived flags are only meaningful while a tile is in flight.
   assign w_active = (r_state == SEQ_LOAD_W) || (r_state == SEQ_LOAD_X) ||
                     (r_state == SEQ_STORE_Z);

   assign w_req_valid_o = w_w_valid;
   assign x_req_valid_o = w_x_valid;
   assign z_req_valid_o = w_z_valid;
   assign w_loaded_o    = r_w_loaded;
   assign done_o        = r_done;
   assign busy_o        = r_busy;
   assign accumulate_o  = (k_idx_o != '0);
   assign last_o        = w_active && w_all_last;

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
module tb_redmule_tile_sequencer;

   localparam int CW = 16;

`ifdef REDMULE_SEQ_PERF_EN
   localparam int EXP_STALL = 5;
`else
   localparam int EXP_STALL = 0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          clear_i, start_i, flush_i;
   logic [CW-1:0] m_tiles_i, n_tiles_i, k_tiles_i;
   logic          w_req_valid_o, w_req_ready_i, w_beat_valid_i;
   logic          x_req_valid_o, x_req_ready_i;
   logic          z_req_valid_o, z_req_ready_i;
   logic          w_loaded_o;
   logic [CW-1:0] m_idx_o, n_idx_o, k_idx_o;
   logic          accumulate_o, last_o, busy_o, done_o;
   logic [31:0]   stall_cnt_o;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk_i = ~clk_i;

   redmule_tile_sequencer #(.CntWidth(CW)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .start_i        (start_i),
      .flush_i        (flush_i),
      .m_tiles_i      (m_tiles_i),
      .n_tiles_i      (n_tiles_i),
      .k_tiles_i      (k_tiles_i),
      .w_req_valid_o  (w_req_valid_o),
      .w_req_ready_i  (w_req_ready_i),
      .w_beat_valid_i (w_beat_valid_i),
      .x_req_valid_o  (x_req_valid_o),
      .x_req_ready_i  (x_req_ready_i),
      .z_req_valid_o  (z_req_valid_o),
      .z_req_ready_i  (z_req_ready_i),
      .w_loaded_o     (w_loaded_o),
      .m_idx_o        (m_idx_o),
      .n_idx_o        (n_idx_o),
      .k_idx_o        (k_idx_o),
      .accumulate_o   (accumulate_o),
      .last_o         (last_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   typedef struct {
      int m, n, k;
      int exp_w, exp_x, exp_z, exp_ld, exp_done;
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_counts(input int m, input int n, input int k);
      m_tiles_i = CW'(m);
      n_tiles_i = CW'(n);
      k_tiles_i = CW'(k);
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         if (done_o) seen = 1'b1;
         else step();
      end
      chk({name, "_done_seen"}, 64'(seen), 64'd1);
      step();
   endtask

   // Runs one full sequence with all readies high and beats streaming,
   // checking tile order and flags at every X request against a loop model.
   task automatic run_seq(input int vi, input int m, input int n, input int k,
                          output int nw, output int nx, output int nz,
                          output int nl, output int nd);
      int  mi = 0, ni = 0, ki = 0, nexcl = 0;
      bit  fin = 1'b0;
      nw = 0; nx = 0; nz = 0; nl = 0; nd = 0;
      set_counts(m, n, k);
      w_req_ready_i = 1'b1; x_req_ready_i = 1'b1; z_req_ready_i = 1'b1;
      w_beat_valid_i = 1'b1;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int c = 0; c < 3000 && !fin; c++) begin
         if (int'(w_req_valid_o) + int'(x_req_valid_o) + int'(z_req_valid_o) > 1) nexcl++;
         if (w_req_valid_o) nw++;
         if (z_req_valid_o) nz++;
         if (w_loaded_o) nl++;
         if (x_req_valid_o) begin
            nx++;
            chk($sformatf("v%0d_idx_m", vi), 64'(m_idx_o), 64'(mi));
            chk($sformatf("v%0d_idx_n", vi), 64'(n_idx_o), 64'(ni));
            chk($sformatf("v%0d_idx_k", vi), 64'(k_idx_o), 64'(ki));
            chk($sformatf("v%0d_accum", vi), 64'(accumulate_o), 64'(ki != 0));
            chk($sformatf("v%0d_last", vi), 64'(last_o),
                64'((mi == m-1) && (ni == n-1) && (ki == k-1)));
            ki++;
            if (ki == k) begin
               ki = 0; ni++;
               if (ni == n) begin ni = 0; mi++; end
            end
         end
         if (done_o) begin
            nd++;
            fin = 1'b1;
         end else begin
            step();
         end
      end
      chk($sformatf("v%0d_finished", vi), 64'(fin), 64'd1);
      chk($sformatf("v%0d_one_valid", vi), 64'(nexcl), 64'd0);
      w_beat_valid_i = 1'b0;
      step();
      chk($sformatf("v%0d_idle_after", vi), 64'(busy_o), 64'd0);
   endtask

   initial begin
      int nw, nx, nz, nl, nd;

      //          m  n  k   W   X   Z  ld  done
      vecs[0] = '{1, 1, 1,  1,  1,  1,  1, 1};
      vecs[1] = '{2, 2, 3, 12, 12,  4, 12, 1};
      vecs[2] = '{1, 3, 2,  6,  6,  3,  6, 1};
      vecs[3] = '{1, 2, 0,  0,  0,  0,  0, 1};
      vecs[4] = '{2, 1, 1,  2,  2,  2,  2, 1};

      rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
      set_counts(1, 1, 1);
      w_req_ready_i = 1'b0; x_req_ready_i = 1'b0; z_req_ready_i = 1'b0;
      w_beat_valid_i = 1'b0;
      step(); step();
      rst_ni = 1'b1;
      step();

      // Reset state
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_wld", 64'(w_loaded_o), 64'd0);
      chk("rst_valids", 64'({w_req_valid_o, x_req_valid_o, z_req_valid_o}), 64'd0);
      chk("rst_idx", 64'({m_idx_o, n_idx_o, k_idx_o}), 64'd0);
      chk("rst_flags", 64'({accumulate_o, last_o}), 64'd0);
      chk("rst_stall", 64'(stall_cnt_o), 64'd0);

      // Table-driven full sequences
      for (int i = 0; i < 5; i++) begin
         run_seq(i, vecs[i].m, vecs[i].n, vecs[i].k, nw, nx, nz, nl, nd);
         chk($sformatf("v%0d_w_reqs", i), 64'(nw), 64'(vecs[i].exp_w));
         chk($sformatf("v%0d_x_reqs", i), 64'(nx), 64'(vecs[i].exp_x));
         chk($sformatf("v%0d_z_reqs", i), 64'(nz), 64'(vecs[i].exp_z));
         chk($sformatf("v%0d_w_loaded", i), 64'(nl), 64'(vecs[i].exp_ld));
         chk($sformatf("v%0d_done", i), 64'(nd), 64'(vecs[i].exp_done));
      end

      // Beat-accurate single tile: w_loaded after exactly 16 beats
      set_counts(1, 1, 1);
      w_req_ready_i = 1'b1; x_req_ready_i = 1'b1; z_req_ready_i = 1'b1;
      w_beat_valid_i = 1'b0;
      start_i = 1'b1; step(); start_i = 1'b0;
      chk("a_w_valid", 64'(w_req_valid_o), 64'd1);
      for (int b = 1; b <= 16; b++) begin
         w_beat_valid_i = 1'b1;
         step();
         chk($sformatf("a_wld_beat%0d", b), 64'(w_loaded_o), 64'(b == 16));
      end
      w_beat_valid_i = 1'b0;
      chk("a_x_valid", 64'(x_req_valid_o), 64'd1);
      step();
      chk("a_z_valid", 64'(z_req_valid_o), 64'd1);
      step();
      chk("a_done", 64'(done_o), 64'd1);
      step();
      chk("a_done_pulse", 64'(done_o), 64'd0);
      chk("a_idle", 64'(busy_o), 64'd0);

      // Start coincident with flush: flush wins
      start_i = 1'b1; flush_i = 1'b1; step(); start_i = 1'b0; flush_i = 1'b0;
      chk("sf_busy", 64'(busy_o), 64'd0);
      chk("sf_w_valid", 64'(w_req_valid_o), 64'd0);

      // Z backpressure: valid held, indices frozen, stalls counted
      set_counts(1, 1, 1);
      z_req_ready_i = 1'b0;
      w_beat_valid_i = 1'b1;
      start_i = 1'b1; step(); start_i = 1'b0;
      for (int c = 0; c < 100 && !z_req_valid_o; c++) step();
      chk("b_z_reached", 64'(z_req_valid_o), 64'd1);
      w_beat_valid_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("b_z_hold%0d", c), 64'(z_req_valid_o), 64'd1);
         chk($sformatf("b_idx_frozen%0d", c), 64'({m_idx_o, n_idx_o, k_idx_o}), 64'd0);
         step();
      end
      chk("b_stall", 64'(stall_cnt_o), 64'(EXP_STALL));
      chk("b_z_still", 64'(z_req_valid_o), 64'd1);
      z_req_ready_i = 1'b1;
      step();
      chk("b_done", 64'(done_o), 64'd1);
      step();
      chk("b_stall_held", 64'(stall_cnt_o), 64'(EXP_STALL));
      clear_i = 1'b1; step(); clear_i = 1'b0;
      chk("b_stall_clear", 64'(stall_cnt_o), 64'd0);

      // Flush in LOAD_W of the second k tile after 7 beats
      set_counts(1, 1, 2);
      w_beat_valid_i = 1'b0;
      start_i = 1'b1; step(); start_i = 1'b0;
      for (int b = 1; b <= 16; b++) begin w_beat_valid_i = 1'b1; step(); end
      w_beat_valid_i = 1'b0;
      step();
      chk("c_k1", 64'(k_idx_o), 64'd1);
      chk("c_w_valid", 64'(w_req_valid_o), 64'd1);
      for (int b = 1; b <= 7; b++) begin w_beat_valid_i = 1'b1; step(); end
      w_beat_valid_i = 1'b0;
      flush_i = 1'b1; step(); flush_i = 1'b0;
      chk("c_busy", 64'(busy_o), 64'd0);
      chk("c_idx", 64'({m_idx_o, n_idx_o, k_idx_o}), 64'd0);
      chk("c_w_valid_drop", 64'(w_req_valid_o), 64'd0);
      chk("c_wld", 64'(w_loaded_o), 64'd0);
      chk("c_done", 64'(done_o), 64'd0);
      step();
      chk("c_no_done", 64'(done_o), 64'd0);
      start_i = 1'b1; step(); start_i = 1'b0;
      for (int b = 1; b <= 16; b++) begin
         w_beat_valid_i = 1'b1;
         step();
         chk($sformatf("c_restart_beat%0d", b), 64'(w_loaded_o), 64'(b == 16));
      end
      wait_done("c", 200);
      w_beat_valid_i = 1'b0;

      // 20 beats into one tile: single pulse, extras don't carry over
      set_counts(1, 1, 2);
      x_req_ready_i = 1'b0;
      start_i = 1'b1; step(); start_i = 1'b0;
      for (int b = 1; b <= 20; b++) begin
         w_beat_valid_i = 1'b1;
         step();
         chk($sformatf("d_beat%0d", b), 64'(w_loaded_o), 64'(b == 16));
      end
      w_beat_valid_i = 1'b0;
      chk("d_x_valid", 64'(x_req_valid_o), 64'd1);
      x_req_ready_i = 1'b1;
      step();
      chk("d_k1", 64'(k_idx_o), 64'd1);
      chk("d_accum", 64'(accumulate_o), 64'd1);
      for (int b = 1; b <= 16; b++) begin
         w_beat_valid_i = 1'b1;
         step();
         chk($sformatf("d_next_beat%0d", b), 64'(w_loaded_o), 64'(b == 16));
      end
      wait_done("d", 200);
      w_beat_valid_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
